ndn_packet_parser: RTL and testbench
====================================

Name: ndn_packet_parser

Overview:
- Upstream of pit_hash_table and the FIB: consumes the byte stream from the MCU-side SPI receiver and decodes NDN framing.
- Emits a parsed header (prefix, prefix length, metadata, interest/data flag) over a valid/ready handshake.
- For data packets, passes the payload bytes through on a separate byte stream.
- Detects malformed frames and reports them.

Parameters:
- MAX_PREFIX_BYTES, 8, maximum prefix byte count N; values of N above this are rejected.
- TYPE_INTEREST, 8'h05, type byte value for an interest packet.
- TYPE_DATA, 8'h06, type byte value for a data packet.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_byte  in  8  byte from the SPI receiver
- in_valid  in  1  in_byte is valid
- in_last  in  1  in_byte is the final byte of the frame
- in_ready  out  1  parser accepts in_byte this cycle
- hdr_prefix  out  64  prefix, MSB-first, left-aligned, zero-filled below
- hdr_length  out  6  N*8-1, the index of the last valid prefix bit
- hdr_metadata  out  8  metadata byte
- hdr_interest  out  1  1 = interest, 0 = data
- hdr_valid  out  1  header outputs are valid
- hdr_ready  in  1  consumer takes the header
- out_byte  out  8  payload byte
- out_valid  out  1  payload byte is valid
- out_last  out  1  final payload byte
- out_ready  in  1  consumer takes the payload byte
- err  out  1  one-cycle error pulse
- err_code  out  2  1 = bad type, 2 = bad N, 3 = framing; held until the next err

Behaviour:
- Frame format: TYPE, NLEN (bits [3:0] = N; bits [7:4] ignored), N prefix bytes, META; data packets add PLEN (P, 0..255) followed by P payload bytes.
- Transfers:
  - An input byte is accepted when in_valid && in_ready.
  - A header transfer completes when hdr_valid && hdr_ready.
  - A payload transfer completes when out_valid && out_ready.
- Reset (asynchronous, rst=0): state IDLE; all outputs 0, including hdr_prefix and err_code; counters cleared. Reset mid-frame abandons the frame; the parser restarts at IDLE with no err.
- States:
  - IDLE:
    - in_ready = 1.
    - Accept TYPE; latch hdr_interest.
    - Known type -> NLEN. Unknown type -> err, code 1, then DROP; if in_last is set, return to IDLE instead.
  - NLEN:
    - in_ready = 1.
    - N = 0 or N > MAX_PREFIX_BYTES -> err, code 2, then DROP.
    - Otherwise clear hdr_prefix, load the byte counter with N, go to PREFIX.
  - PREFIX:
    - in_ready = 1.
    - Byte k (0-based) is written to hdr_prefix[63-8k -: 8].
    - Counter reaching 0 -> META.
  - META:
    - in_ready = 1.
    - Latch hdr_metadata and set hdr_length = N*8-1.
    - hdr_valid rises on the next cycle -> HDR.
  - HDR:
    - in_ready = 0, so input is backpressured.
    - Header outputs are stable while hdr_valid=1.
    - On the handshake, hdr_valid falls on the next cycle.
    - Interest -> IDLE. Data -> PLEN.
  - PLEN:
    - in_ready = 1.
    - P = 0 -> IDLE.
    - Otherwise load the counter with P -> PAYLOAD.
  - PAYLOAD (combinational pass-through):
    - out_byte = in_byte, out_valid = in_valid, in_ready = out_ready.
    - out_last = 1 when counter == 1.
    - Counter decrements on each transfer; reaching 0 -> IDLE.
  - DROP:
    - in_ready = 1; bytes are discarded.
    - Accepting in_last -> IDLE.
- Framing rules (err code 3):
  - in_last on any byte before the expected end: err, then IDLE. If this happens in TYPE, NLEN, PREFIX or META, no header is emitted. Truncated payload: the last accepted byte is forwarded with out_last=0.
  - Missing in_last on the expected final byte (META for an interest, PLEN when P = 0, or the last payload byte): err, then DROP. The header has already been emitted.
- If a byte fails both a type/N check and a framing check, the type/N code wins and only one err pulse is issued.
- err pulses for exactly one cycle; err_code is registered with it.
- Throughput: one byte per cycle in all accepting states. The header adds one bubble cycle plus the hdr_ready wait.

Test Plan:
- Interest 05,02,AB,CD,7E(last); hdr_ready=1 -> hdr_valid 1 cycle after META; prefix=64'hABCD_0000_0000_0000, length=15, metadata=8'h7E, interest=1; no err.
- Data 06,01,11,22,03,A0,A1,A2(last) with out_ready toggling every cycle -> header prefix=64'h1100_0000_0000_0000, length=7; payload A0,A1,A2 appears with out_last only on A2; in_ready mirrors out_ready.
- Type byte 09 followed by 4 bytes with the last flagged -> err=1 with code 1; all bytes dropped; hdr_valid never asserts; next valid interest parses correctly.
- N=9 and, separately, N=0 -> err code 2; DROP until in_last. N=8 with bytes 01..08 -> prefix=64'h0102030405060708, length=63.
- hdr_ready held 0 for 10 cycles -> in_ready=0 and header stable for those cycles. Interest whose META lacks in_last -> header emitted, then err code 3, DROP. in_last on the 2nd prefix byte -> err code 3, no header.
- rst asserted mid-PAYLOAD -> all outputs 0 immediately (asynchronous). After release, a fresh interest parses with no err.

Source files
------------

// File: rtl/ndn_packet_parser.sv
// NDN frame decoder: splits the SPI byte stream into a parsed header (valid/ready)
// and a payload byte pass-through, flagging malformed frames with a one-cycle err.
module ndn_packet_parser #(
    parameter int         MAX_PREFIX_BYTES = 8,
    parameter logic [7:0] TYPE_INTEREST    = 8'h05,
    parameter logic [7:0] TYPE_DATA        = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] hdr_prefix,
    output logic [5:0]  hdr_length,
    output logic [7:0]  hdr_metadata,
    output logic        hdr_interest,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_NLEN, S_PREFIX, S_META, S_HDR, S_PLEN, S_PAYLOAD, S_DROP
    } state_t;

    state_t      state, state_next;
    logic [7:0]  cnt;
    logic [2:0]  n_bytes;
    logic        drop_after_hdr;
    logic        err_set;
    logic [1:0]  err_code_set;
    logic        accept;
    logic [3:0]  nlen;
    logic        nlen_bad;
    logic [2:0]  prefix_idx;
    logic [5:0]  prefix_base;

    assign accept   = in_valid && in_ready;
    assign nlen     = in_byte[3:0];
    assign nlen_bad = (nlen == 4'd0) || (nlen > 4'(MAX_PREFIX_BYTES));

    // N is kept modulo 8: N=8 stores 0, which still yields index 0 first and length 63.
    assign prefix_idx  = n_bytes - cnt[2:0];
    assign prefix_base = 6'd63 - {prefix_idx, 3'b000};

    assign hdr_valid = (state == S_HDR);
    assign out_valid = (state == S_PAYLOAD) && in_valid;
    assign out_byte  = (state == S_PAYLOAD) ? in_byte : 8'h00;
    assign out_last  = (state == S_PAYLOAD) && (cnt == 8'd1);

    // in_ready is forced low while reset is held so every output reads 0.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            case (state)
                S_HDR:     in_ready = 1'b0;
                S_PAYLOAD: in_ready = out_ready;
                default:   in_ready = 1'b1;
            endcase
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next   = state;
        err_set      = 1'b0;
        err_code_set = 2'd0;
        case (state)
            S_IDLE: if (accept) begin
                if (in_byte == TYPE_INTEREST || in_byte == TYPE_DATA) begin
                    if (in_last) begin
                        err_set      = 1'b1;
                        err_code_set = 2'd3;
                    end else begin
                        state_next = S_NLEN;
                    end
                end else begin
                    err_set      = 1'b1;
                    err_code_set = 2'd1;
                    state_next   = in_last ? S_IDLE : S_DROP;
                end
            end
            S_NLEN: if (accept) begin
                if (nlen_bad) begin
                    err_set      = 1'b1;
                    err_code_set = 2'd2;
                    state_next   = in_last ? S_IDLE : S_DROP;
                end else if (in_last) begin
                    err_set      = 1'b1;
                    err_code_set = 2'd3;
                    state_next   = S_IDLE;
                end else begin
                    state_next = S_PREFIX;
                end
            end
            S_PREFIX: if (accept) begin
                if (in_last) begin
                    err_set      = 1'b1;
                    err_code_set = 2'd3;
                    state_next   = S_IDLE;
                end else if (cnt == 8'd1) begin
                    state_next = S_META;
                end
            end
            S_META: if (accept) begin
                // An interest missing in_last still emits its header before dropping.
                if (hdr_interest) begin
                    state_next   = S_HDR;
                    err_set      = !in_last;
                    err_code_set = in_last ? 2'd0 : 2'd3;
                end else if (in_last) begin
                    err_set      = 1'b1;
                    err_code_set = 2'd3;
                    state_next   = S_IDLE;
                end else begin
                    state_next = S_HDR;
                end
            end
            S_HDR: if (hdr_ready) begin
                if (!hdr_interest)      state_next = S_PLEN;
                else if (drop_after_hdr) state_next = S_DROP;
                else                     state_next = S_IDLE;
            end
            S_PLEN: if (accept) begin
                if (in_byte == 8'd0) begin
                    err_set      = !in_last;
                    err_code_set = in_last ? 2'd0 : 2'd3;
                    state_next   = in_last ? S_IDLE : S_DROP;
                end else if (in_last) begin
                    err_set      = 1'b1;
                    err_code_set = 2'd3;
                    state_next   = S_IDLE;
                end else begin
                    state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: if (accept) begin
                if (cnt == 8'd1) begin
                    err_set      = !in_last;
                    err_code_set = in_last ? 2'd0 : 2'd3;
                    state_next   = in_last ? S_IDLE : S_DROP;
                end else if (in_last) begin
                    err_set      = 1'b1;
                    err_code_set = 2'd3;
                    state_next   = S_IDLE;
                end
            end
            S_DROP: if (accept && in_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_prefix     <= '0;
            hdr_length     <= '0;
            hdr_metadata   <= '0;
            hdr_interest   <= 1'b0;
            cnt            <= '0;
            n_bytes        <= '0;
            drop_after_hdr <= 1'b0;
            err            <= 1'b0;
            err_code       <= '0;
        end else begin
            err <= err_set;
            if (err_set) err_code <= err_code_set;
            if (accept) begin
                case (state)
                    S_IDLE: hdr_interest <= (in_byte == TYPE_INTEREST);
                    S_NLEN: if (!nlen_bad) begin
                        hdr_prefix <= '0;
                        n_bytes    <= nlen[2:0];
                        cnt        <= {4'd0, nlen};
                    end
                    S_PREFIX: begin
                        hdr_prefix[prefix_base -: 8] <= in_byte;
                        cnt                          <= cnt - 8'd1;
                    end
                    S_META: begin
                        hdr_metadata   <= in_byte;
                        hdr_length     <= {n_bytes, 3'b000} - 6'd1;
                        drop_after_hdr <= !in_last;
                    end
                    S_PLEN:    cnt <= in_byte;
                    S_PAYLOAD: cnt <= cnt - 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ndn_packet_parser.sv
// Self-checking bench for ndn_packet_parser: directed frames plus random frames
// scored against a frame-level reference parser.
module tb_ndn_packet_parser;

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed {
        logic [63:0] prefix;
        logic [5:0]  length;
        logic [7:0]  meta;
        logic        interest;
    } hdr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [63:0] hdr_prefix;
    logic [5:0]  hdr_length;
    logic [7:0]  hdr_metadata;
    logic        hdr_interest;
    logic        hdr_valid;
    logic        hdr_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 out_ready toggles, 3 hdr_ready held low
    bit gaps = 1'b0;

    hdr_t       got_hdr[$], exp_hdr[$];
    logic [8:0] got_pay[$], exp_pay[$];
    logic [1:0] got_err[$], exp_err[$];

    ndn_packet_parser dut (
        .clk(clk), .rst(rst),
        .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .hdr_prefix(hdr_prefix), .hdr_length(hdr_length), .hdr_metadata(hdr_metadata),
        .hdr_interest(hdr_interest), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (hdr_valid && hdr_ready)
                got_hdr.push_back(hdr_t'({hdr_prefix, hdr_length, hdr_metadata, hdr_interest}));
            if (out_valid && out_ready) got_pay.push_back({out_last, out_byte});
            if (err) got_err.push_back(err_code);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [93:0] all_outs();
        return {in_ready, hdr_prefix, hdr_length, hdr_metadata, hdr_interest, hdr_valid,
                out_byte, out_valid, out_last, err, err_code};
    endfunction

    // Reference parser: walks a whole frame by byte position (last flag on final byte).
    function automatic void model(input byte_q_t b);
        int          len, n, m, p, pend;
        logic [63:0] pf;
        hdr_t        h;
        len = b.size();
        if (b[0] != 8'h05 && b[0] != 8'h06) begin exp_err.push_back(2'd1); return; end
        if (len == 1) begin exp_err.push_back(2'd3); return; end
        n = int'(b[1] & 8'h0F);
        if (n == 0 || n > 8) begin exp_err.push_back(2'd2); return; end
        m = n + 2;
        if (len - 1 < m) begin exp_err.push_back(2'd3); return; end
        pf = '0;
        for (int k = 0; k < n; k++) pf[63 - 8*k -: 8] = b[2 + k];
        h.prefix   = pf;
        h.length   = 6'(n * 8 - 1);
        h.meta     = b[m];
        h.interest = (b[0] == 8'h05);
        if (h.interest) begin
            exp_hdr.push_back(h);
            if (len - 1 != m) exp_err.push_back(2'd3);
            return;
        end
        if (len - 1 == m) begin exp_err.push_back(2'd3); return; end
        exp_hdr.push_back(h);
        p = int'(b[m + 1]);
        if (p == 0) begin
            if (len - 1 != m + 1) exp_err.push_back(2'd3);
            return;
        end
        if (len - 1 == m + 1) begin exp_err.push_back(2'd3); return; end
        pend = m + 1 + p;
        for (int i = m + 2; i <= pend && i <= len - 1; i++)
            exp_pay.push_back({(i == pend), b[i]});
        if (len - 1 != pend) exp_err.push_back(2'd3);
    endfunction

    task automatic drive_readies();
        case (ready_mode)
            0: begin hdr_ready = 1'b1; out_ready = 1'b1; end
            1: begin hdr_ready = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); end
            2: begin hdr_ready = 1'b1; out_ready = ~out_ready; end
            default: begin hdr_ready = 1'b0; out_ready = 1'b1; end
        endcase
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last);
        bit acc;
        int cyc;
        acc = 1'b0;
        cyc = 0;
        in_byte = b;
        in_last = last;
        while (!acc && cyc < 100) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_readies();
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (in_ready !== out_ready) begin
                    failures++;
                    $display("FAIL in_ready_mirror: in_ready=%b required=%b", in_ready, out_ready);
                end
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: byte %h not accepted within 100 cycles", b);
        end
    endtask

    task automatic send_bytes(input byte_q_t q);
        model(q);
        for (int i = 0; i < q.size(); i++) drive_byte(q[i], (i == q.size() - 1));
    endtask

    task automatic finish_frame(input string name);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            drive_readies();
            @(posedge clk);
            #1;
        end
        checks++;
        if (got_hdr.size() != exp_hdr.size()) begin
            failures++;
            $display("FAIL %s hdr_count: got %0d required %0d", name, got_hdr.size(), exp_hdr.size());
        end else begin
            foreach (exp_hdr[i]) begin
                checks++;
                if (got_hdr[i] !== exp_hdr[i]) begin
                    failures++;
                    $display("FAIL %s hdr: got %h required %h", name, got_hdr[i], exp_hdr[i]);
                end
            end
        end
        checks++;
        if (got_pay.size() != exp_pay.size()) begin
            failures++;
            $display("FAIL %s payload_count: got %0d required %0d", name, got_pay.size(), exp_pay.size());
        end else begin
            foreach (exp_pay[i]) begin
                checks++;
                if (got_pay[i] !== exp_pay[i]) begin
                    failures++;
                    $display("FAIL %s payload[%0d]: got %h required %h", name, i, got_pay[i], exp_pay[i]);
                end
            end
        end
        checks++;
        if (got_err.size() != exp_err.size()) begin
            failures++;
            $display("FAIL %s err_count: got %0d required %0d", name, got_err.size(), exp_err.size());
        end else begin
            foreach (exp_err[i]) begin
                checks++;
                if (got_err[i] !== exp_err[i]) begin
                    failures++;
                    $display("FAIL %s err_code: got %0d required %0d", name, got_err[i], exp_err[i]);
                end
            end
        end
        got_hdr.delete(); exp_hdr.delete();
        got_pay.delete(); exp_pay.delete();
        got_err.delete(); exp_err.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || hdr_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b hdr_valid=%b err=%b required 1 0 0",
                     in_ready, hdr_valid, err);
        end
    endtask

    task automatic test_interest();
        byte_q_t q;
        ready_mode = 0;
        gaps = 1'b0;
        q = '{8'h05, 8'h02, 8'hAB, 8'hCD, 8'h7E};
        send_bytes(q);
        checks++;
        if (hdr_valid !== 1'b1 || hdr_prefix !== 64'hABCD_0000_0000_0000 || hdr_length !== 6'd15 ||
            hdr_metadata !== 8'h7E || hdr_interest !== 1'b1) begin
            failures++;
            $display("FAIL interest_hdr_timing: valid=%b prefix=%h len=%0d meta=%h int=%b required 1 abcd000000000000 15 7e 1",
                     hdr_valid, hdr_prefix, hdr_length, hdr_metadata, hdr_interest);
        end
        finish_frame("interest");
    endtask

    task automatic test_data_toggle();
        byte_q_t q;
        ready_mode = 2;
        gaps = 1'b0;
        q = '{8'h06, 8'h01, 8'h11, 8'h22, 8'h03, 8'hA0, 8'hA1, 8'hA2};
        send_bytes(q);
        finish_frame("data_toggle");
        ready_mode = 0;
    endtask

    task automatic test_bad_type();
        byte_q_t q;
        q = '{8'h09, 8'h02, 8'hAB, 8'hCD, 8'h7E};
        send_bytes(q);
        finish_frame("bad_type");
        q = '{8'h05, 8'h01, 8'h5A, 8'h33};
        send_bytes(q);
        finish_frame("after_bad_type");
    endtask

    task automatic test_bad_n();
        byte_q_t q;
        q = '{8'h05, 8'h09, 8'h01, 8'h02, 8'h03};
        send_bytes(q);
        finish_frame("n_nine");
        q = '{8'h06, 8'h00, 8'hAA, 8'hBB};
        send_bytes(q);
        finish_frame("n_zero");
        q = '{8'h05, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEE};
        send_bytes(q);
        checks++;
        if (hdr_prefix !== 64'h0102030405060708 || hdr_length !== 6'd63) begin
            failures++;
            $display("FAIL n_max: prefix=%h len=%0d required 0102030405060708 63", hdr_prefix, hdr_length);
        end
        finish_frame("n_max");
    endtask

    task automatic test_hdr_stall();
        byte_q_t q;
        ready_mode = 3;
        q = '{8'h05, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'h99};
        send_bytes(q);
        in_byte  = 8'h05;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || hdr_valid !== 1'b1 || hdr_prefix !== 64'hDEAD_BE00_0000_0000 ||
                hdr_length !== 6'd23 || hdr_metadata !== 8'h99) begin
                failures++;
                $display("FAIL hdr_stall cycle %0d: in_ready=%b valid=%b prefix=%h len=%0d meta=%h required 0 1 deadbe0000000000 23 99",
                         c, in_ready, hdr_valid, hdr_prefix, hdr_length, hdr_metadata);
            end
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        finish_frame("hdr_stall");
    endtask

    task automatic test_framing();
        byte_q_t q;
        q = '{8'h05, 8'h01, 8'h33, 8'h44, 8'h55};
        send_bytes(q);
        finish_frame("meta_no_last");
        q = '{8'h05, 8'h03, 8'h11, 8'h22};
        send_bytes(q);
        finish_frame("early_last_prefix");
        q = '{8'h06, 8'h01, 8'h77, 8'h88, 8'h00, 8'h99};
        send_bytes(q);
        finish_frame("plen_zero_no_last");
        q = '{8'h06, 8'h01, 8'h12, 8'h34, 8'h04, 8'hB0, 8'hB1};
        send_bytes(q);
        finish_frame("truncated_payload");
        q = '{8'h05, 8'h01, 8'h42, 8'h24};
        send_bytes(q);
        finish_frame("clean_after_err");
        checks++;
        if (err_code !== 2'd3) begin
            failures++;
            $display("FAIL err_code_hold: got %0d required 3", err_code);
        end
    endtask

    task automatic test_random(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            byte_q_t    q;
            int         kind, n, p, len, r;
            logic [7:0] t;
            kind = $urandom_range(0, 9);
            t = (kind == 0) ? 8'($urandom_range(7, 255)) : ((kind < 5) ? 8'h05 : 8'h06);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8);
            q.push_back(t);
            q.push_back({4'($urandom_range(0, 15)), 4'(n)});
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            q.push_back(8'($urandom));
            if (t == 8'h06) begin
                p = $urandom_range(0, 6);
                q.push_back(8'(p));
                for (int k = 0; k < p; k++) q.push_back(8'($urandom));
            end
            r = $urandom_range(0, 5);
            if (r == 0) begin
                len = $urandom_range(1, q.size());
                while (q.size() > len) void'(q.pop_back());
            end else if (r == 1) begin
                len = $urandom_range(1, 3);
                for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            end
            ready_mode = $urandom_range(0, 2);
            gaps = 1'($urandom_range(0, 1));
            send_bytes(q);
            finish_frame("random");
        end
        ready_mode = 0;
        gaps = 1'b0;
    endtask

    task automatic test_reset_mid_payload();
        byte_q_t q;
        ready_mode = 0;
        gaps = 1'b0;
        q = '{8'h06, 8'h01, 8'hAA, 8'hBB, 8'h05, 8'hC0};
        for (int i = 0; i < q.size(); i++) drive_byte(q[i], 1'b0);
        in_byte  = 8'hC1;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_byte !== 8'hC1) begin
            failures++;
            $display("FAIL mid_payload_passthrough: out_valid=%b out_byte=%h required 1 c1", out_valid, out_byte);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs: got %h required 0", all_outs());
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        got_hdr.delete(); got_pay.delete(); got_err.delete();
        q = '{8'h05, 8'h02, 8'h12, 8'h34, 8'h56};
        send_bytes(q);
        finish_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_interest();
        test_data_toggle();
        test_bad_type();
        test_bad_n();
        test_hdr_stall();
        test_framing();
        test_random(60);
        test_reset_mid_payload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
